bus_mn: RTL and testbench

Parametrised multi-master, multi-slave shared bus for the factorial computation system: successor to the single-master two-slave bus. Arbitrates among N_MASTER requesters with registered round-robin grants and bus locking. Decodes the granted address against a base/mask map to one of N_SLAVE selects, and returns registered read data plus a decode-error flag. It sits between the masters (testbench/CPU-side driver, DMA) and the slaves (memory, factorial core).

---
 rtl/bus_pkg.sv | 23 ++
 rtl/bus_rr_arbiter.sv | 86 ++++++++
 rtl/bus_mn.sv | 99 +++++++++
 tb/tb_bus_mn.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the multi-master bus: default widths, default slave map
// and the one-hot to index helper used by the arbiter.
package bus_pkg;

    localparam int BUS_ADDR_W = 16;
    localparam int BUS_DATA_W = 64;

    localparam logic [15:0] MEM_BASE  = 16'h0000;
    localparam logic [15:0] MEM_MASK  = 16'hF800;
    localparam logic [15:0] FACT_BASE = 16'h7000;
    localparam logic [15:0] FACT_MASK = 16'hFFE0;

    // OR-reduction encoder; only meaningful for a one-hot (or zero) input.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] onehot);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) idx = idx | 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/bus_rr_arbiter.sv
// Registered round-robin arbiter with bus lock: the owner keeps the grant until it
// drops its request, then the next requester after it is granted on the same edge.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | grant_q == 0; first requester after last_q wins next edge
//   ST_OWNED  | grant_q one-hot; held while owner requests, else hand over
module bus_rr_arbiter
    import bus_pkg::*;
#(
    parameter int N_MASTER = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_MASTER-1:0] req_i,
    output logic [N_MASTER-1:0] grant_o
);

    localparam int LW = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OWNED = 1'b1;

    logic [N_MASTER-1:0] grant_q, grant_d;
    logic [LW-1:0]       last_q, last_d;
    logic [0:0]          state;
    logic [LW-1:0]       owner;
    logic [LW-1:0]       base;
    logic [LW-1:0]       ix;
    logic [LW-1:0]       cand;
    logic                found;

    assign state = (grant_q == '0) ? ST_IDLE : ST_OWNED;
    assign owner = LW'(onehot_to_idx(8'(grant_q)));

    // Search starts after the previous owner, or after the current owner on release.
    always_comb begin
        base  = (state == ST_IDLE) ? last_q : owner;
        found = 1'b0;
        cand  = '0;
        ix    = '0;
        for (int off = 1; off <= N_MASTER; off++) begin
            ix = LW'((int'(base) + off) % N_MASTER);
            if (!found && req_i[ix]) begin
                found = 1'b1;
                cand  = ix;
            end
        end
    end

    always_comb begin
        grant_d = grant_q;
        last_d  = last_q;
        case (state)
            ST_IDLE: begin
                if (found) begin
                    grant_d       = '0;
                    grant_d[cand] = 1'b1;
                end
            end
            ST_OWNED: begin
                if (!req_i[owner]) begin
                    grant_d = '0;
                    if (found) grant_d[cand] = 1'b1;
                    last_d = owner;
                end
            end
            default: begin
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_q <= '0;
            last_q  <= LW'(N_MASTER - 1);
        end else begin
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign grant_o = grant_q;

endmodule

// File: rtl/bus_mn.sv
// Multi-master, multi-slave shared bus: round-robin arbitration with lock, base/mask
// address decode with lowest-index priority, registered read return and decode error.
module bus_mn
    import bus_pkg::*;
#(
    parameter int N_MASTER = 2,
    parameter int N_SLAVE  = 2,
    parameter int ADDR_W   = BUS_ADDR_W,
    parameter int DATA_W   = BUS_DATA_W,
    parameter logic [N_SLAVE*ADDR_W-1:0] SLV_BASE = {FACT_BASE, MEM_BASE},
    parameter logic [N_SLAVE*ADDR_W-1:0] SLV_MASK = {FACT_MASK, MEM_MASK}
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [N_MASTER-1:0]          m_req,
    input  logic [N_MASTER-1:0]          m_wr,
    input  logic [N_MASTER*ADDR_W-1:0]   m_addr,
    input  logic [N_MASTER*DATA_W-1:0]   m_dout,
    output logic [N_MASTER-1:0]          m_grant,
    output logic [DATA_W-1:0]            m_din,
    output logic                         m_err,
    input  logic [N_SLAVE*DATA_W-1:0]    s_dout,
    output logic [N_SLAVE-1:0]           s_sel,
    output logic                         s_wr,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_din
);

    logic               grant_valid;
    logic [N_SLAVE-1:0] hit;
    logic               hit_taken;
    logic [N_SLAVE-1:0] sel_q;
    logic               err_q, err_d;

    bus_rr_arbiter #(
        .N_MASTER (N_MASTER)
    ) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req_i   (m_req),
        .grant_o (m_grant)
    );

    assign grant_valid = |m_grant;

    // Grant is one-hot, so an AND-OR mux is enough and idles at zero.
    always_comb begin
        s_wr   = 1'b0;
        s_addr = '0;
        s_din  = '0;
        for (int m = 0; m < N_MASTER; m++) begin
            if (m_grant[m]) begin
                s_wr   = s_wr | m_wr[m];
                s_addr = s_addr | m_addr[m*ADDR_W +: ADDR_W];
                s_din  = s_din | m_dout[m*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_SLAVE; i++) begin
            hit[i] = (s_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W];
        end
    end

    // Overlapping windows resolve to the lowest slave index.
    always_comb begin
        s_sel     = '0;
        hit_taken = 1'b0;
        for (int i = 0; i < N_SLAVE; i++) begin
            if (grant_valid && hit[i] && !hit_taken) begin
                s_sel[i]  = 1'b1;
                hit_taken = 1'b1;
            end
        end
    end

    assign err_d = grant_valid & ~(|hit);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_q <= '0;
            err_q <= 1'b0;
        end else begin
            sel_q <= s_sel;
            err_q <= err_d;
        end
    end

    always_comb begin
        m_din = '0;
        for (int i = 0; i < N_SLAVE; i++) begin
            if (sel_q[i]) m_din = m_din | s_dout[i*DATA_W +: DATA_W];
        end
    end

    assign m_err = err_q;

endmodule

// File: tb/tb_bus_mn.sv
// Self-checking bench for bus_mn: default 2x2 instance against a behavioural model,
// plus a 4-master, 3-slave instance for the round-robin sweep and decode priority.
module tb_bus_mn;

    localparam int AW = 16;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      m_req, m_wr, m_grant, s_sel;
    logic [2*AW-1:0] m_addr;
    logic [2*DW-1:0] m_dout, s_dout;
    logic [DW-1:0]   m_din, s_din;
    logic            m_err, s_wr;
    logic [AW-1:0]   s_addr;

    bus_mn dut (
        .clk(clk), .reset_n(reset_n), .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr),
        .m_dout(m_dout), .m_grant(m_grant), .m_din(m_din), .m_err(m_err),
        .s_dout(s_dout), .s_sel(s_sel), .s_wr(s_wr), .s_addr(s_addr), .s_din(s_din)
    );

    logic [3:0]      m_req4, m_wr4, m_grant4;
    logic [2:0]      s_sel4;
    logic [4*AW-1:0] m_addr4;
    logic [4*DW-1:0] m_dout4;
    logic [3*DW-1:0] s_dout4;
    logic [DW-1:0]   m_din4, s_din4;
    logic            m_err4, s_wr4;
    logic [AW-1:0]   s_addr4;

    bus_mn #(
        .N_MASTER(4), .N_SLAVE(3),
        .SLV_BASE({16'h7000, 16'h7000, 16'h0000}),
        .SLV_MASK({16'hF000, 16'hFFE0, 16'hF800})
    ) dut4 (
        .clk(clk), .reset_n(reset_n), .m_req(m_req4), .m_wr(m_wr4), .m_addr(m_addr4),
        .m_dout(m_dout4), .m_grant(m_grant4), .m_din(m_din4), .m_err(m_err4),
        .s_dout(s_dout4), .s_sel(s_sel4), .s_wr(s_wr4), .s_addr(s_addr4), .s_din(s_din4)
    );

    int passed = 0;
    int total  = 0;

    // Behavioural model: owner index (-1 idle), last owner, captured slave (-1 none), error.
    int   mo, ml, msel;
    logic merr;

    logic [1:0]    e_grant, e_sel;
    logic [DW-1:0] e_din, e_sdin;
    logic [AW-1:0] e_addr;
    logic          e_wr, e_err;

    function automatic int decode2(input logic [AW-1:0] a);
        if ((a & 16'hF800) == 16'h0000) return 0;
        if ((a & 16'hFFE0) == 16'h7000) return 1;
        return -1;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return AW'($urandom_range(0, 16'h07FF));
            1:       return 16'h7000 | AW'($urandom_range(0, 31));
            2:       return 16'h7020 | AW'($urandom_range(0, 31));
            default: return AW'($urandom());
        endcase
    endfunction

    task automatic model_reset();
        mo = -1; ml = 1; msel = -1; merr = 1'b0;
    endtask

    task automatic calc_exp();
        int d;
        e_grant = '0; e_sel = '0; e_addr = '0; e_wr = 1'b0; e_sdin = '0;
        if (mo >= 0) begin
            e_grant[mo] = 1'b1;
            e_addr = m_addr[mo*AW +: AW];
            e_wr   = m_wr[mo];
            e_sdin = m_dout[mo*DW +: DW];
            d = decode2(e_addr);
            if (d >= 0) e_sel[d] = 1'b1;
        end
        e_din = (msel >= 0) ? s_dout[msel*DW +: DW] : '0;
        e_err = merr;
    endtask

    // Advance the model by one rising edge, then move to the following falling edge.
    task automatic step();
        int d, nxt, base;
        if (mo >= 0) begin
            d = decode2(m_addr[mo*AW +: AW]);
            msel = d;
            merr = (d < 0);
        end else begin
            msel = -1;
            merr = 1'b0;
        end
        if (mo < 0 || !m_req[mo]) begin
            base = (mo < 0) ? ml : mo;
            if (mo >= 0) ml = mo;
            nxt = -1;
            for (int off = 1; off <= 2; off++) begin
                if (nxt < 0 && m_req[(base + off) % 2]) nxt = (base + off) % 2;
            end
            mo = nxt;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic zero_inputs();
        m_req = '0; m_wr = '0; m_addr = '0; m_dout = '0; s_dout = '0;
        m_req4 = '0; m_wr4 = '0; m_addr4 = '0; m_dout4 = '0; s_dout4 = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        zero_inputs();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            m_req = 2'($urandom()); m_wr = 2'($urandom());
            m_addr = 32'($urandom());
            m_dout = {$urandom(), $urandom(), $urandom(), $urandom()};
            s_dout = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(posedge clk);
            @(negedge clk);
            total++; if (m_grant !== 2'b00) $display("FAIL reset_grant act=%b exp=00", m_grant); else passed++;
            total++; if (m_din !== '0) $display("FAIL reset_din act=%h exp=0", m_din); else passed++;
            total++; if (m_err !== 1'b0) $display("FAIL reset_err act=%b exp=0", m_err); else passed++;
            total++; if (s_sel !== 2'b00) $display("FAIL reset_sel act=%b exp=00", s_sel); else passed++;
            total++; if (s_addr !== '0 || s_wr !== 1'b0 || s_din !== '0)
                $display("FAIL reset_slave_side act=%h/%b/%h exp=0/0/0", s_addr, s_wr, s_din); else passed++;
        end
    endtask

    task automatic test_single_read();
        do_reset();
        m_req = 2'b01;
        m_addr[AW-1:0] = 16'h0010;
        s_dout[DW-1:0] = 64'hA5;
        for (int c = 0; c < 4; c++) begin
            s_dout[2*DW-1:DW] = {$urandom(), $urandom()};
            #1; calc_exp();
            total++; if (m_grant !== e_grant) $display("FAIL single_grant c=%0d act=%b exp=%b", c, m_grant, e_grant); else passed++;
            total++; if (s_sel !== e_sel) $display("FAIL single_sel c=%0d act=%b exp=%b", c, s_sel, e_sel); else passed++;
            total++; if (m_din !== e_din) $display("FAIL single_din c=%0d act=%h exp=%h", c, m_din, e_din); else passed++;
            if (c == 1) begin
                total++; if (m_grant !== 2'b01 || s_sel !== 2'b01)
                    $display("FAIL single_first_grant act=%b/%b exp=01/01", m_grant, s_sel); else passed++;
            end
            if (c == 2) begin
                total++; if (m_din !== 64'hA5) $display("FAIL single_read_data act=%h exp=a5", m_din); else passed++;
            end
            step();
        end
        m_req = 2'b00;
        step();
    endtask

    task automatic test_contention();
        logic [1:0] reqs [9];
        reqs = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b00, 2'b11, 2'b11};
        do_reset();
        m_addr = {16'h7008, 16'h0100};
        for (int c = 0; c < 9; c++) begin
            m_req = reqs[c];
            s_dout = {$urandom(), $urandom(), $urandom(), $urandom()};
            #1; calc_exp();
            total++; if (m_grant !== e_grant) $display("FAIL cont_grant c=%0d act=%b exp=%b", c, m_grant, e_grant); else passed++;
            total++; if (s_addr !== e_addr) $display("FAIL cont_addr c=%0d act=%h exp=%h", c, s_addr, e_addr); else passed++;
            total++; if (m_din !== e_din) $display("FAIL cont_din c=%0d act=%h exp=%h", c, m_din, e_din); else passed++;
            if (c == 5) begin
                total++; if (m_grant !== 2'b10) $display("FAIL cont_handover act=%b exp=10", m_grant); else passed++;
            end
            if (c == 8) begin
                total++; if (m_grant !== 2'b01) $display("FAIL cont_rr_again act=%b exp=01", m_grant); else passed++;
            end
            step();
        end
        m_req = 2'b00;
        step();
    endtask

    task automatic test_lock();
        do_reset();
        m_addr = {16'h7010, 16'h0200};
        for (int c = 0; c < 13; c++) begin
            m_req = (c == 0) ? 2'b10 : (c <= 10) ? 2'b11 : 2'b01;
            #1; calc_exp();
            total++; if (m_grant !== e_grant) $display("FAIL lock_grant c=%0d act=%b exp=%b", c, m_grant, e_grant); else passed++;
            total++; if (s_sel !== e_sel) $display("FAIL lock_sel c=%0d act=%b exp=%b", c, s_sel, e_sel); else passed++;
            if (c >= 1 && c <= 11) begin
                total++; if (m_grant !== 2'b10) $display("FAIL lock_hold c=%0d act=%b exp=10", c, m_grant); else passed++;
            end
            if (c == 12) begin
                total++; if (m_grant !== 2'b01) $display("FAIL lock_release act=%b exp=01", m_grant); else passed++;
            end
            step();
        end
        m_req = 2'b00;
        step();
    endtask

    task automatic test_decode();
        logic [AW-1:0] addrs [5];
        addrs = '{16'h7004, 16'h7004, 16'h4000, 16'h0010, 16'h0010};
        do_reset();
        m_req = 2'b01;
        for (int c = 0; c < 5; c++) begin
            m_addr[AW-1:0] = addrs[c];
            m_wr[0] = (c == 2);
            m_dout[DW-1:0] = {$urandom(), $urandom()};
            s_dout = {$urandom(), $urandom(), $urandom(), $urandom()};
            #1; calc_exp();
            total++; if (s_sel !== e_sel) $display("FAIL dec_sel c=%0d act=%b exp=%b", c, s_sel, e_sel); else passed++;
            total++; if (m_err !== e_err) $display("FAIL dec_err c=%0d act=%b exp=%b", c, m_err, e_err); else passed++;
            total++; if (m_din !== e_din) $display("FAIL dec_din c=%0d act=%h exp=%h", c, m_din, e_din); else passed++;
            total++; if (s_wr !== e_wr || s_din !== e_sdin)
                $display("FAIL dec_wr c=%0d act=%b/%h exp=%b/%h", c, s_wr, s_din, e_wr, e_sdin); else passed++;
            if (c == 1) begin
                total++; if (s_sel !== 2'b10) $display("FAIL dec_fact act=%b exp=10", s_sel); else passed++;
            end
            if (c == 2) begin
                total++; if (s_sel !== 2'b00) $display("FAIL dec_miss act=%b exp=00", s_sel); else passed++;
            end
            if (c == 3) begin
                total++; if (m_err !== 1'b1 || m_din !== '0)
                    $display("FAIL dec_err_pulse act=%b/%h exp=1/0", m_err, m_din); else passed++;
            end
            if (c == 4) begin
                total++; if (m_err !== 1'b0) $display("FAIL dec_err_clear act=%b exp=0", m_err); else passed++;
            end
            step();
        end
        m_req = 2'b00; m_wr = 2'b00;
        step();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 300; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (m_req[k]) m_req[k] = ($urandom_range(0, 3) != 0);
                else          m_req[k] = ($urandom_range(0, 1) == 1);
                m_addr[k*AW +: AW] = rand_addr();
                m_dout[k*DW +: DW] = {$urandom(), $urandom()};
                m_wr[k] = 1'($urandom_range(0, 1));
            end
            s_dout = {$urandom(), $urandom(), $urandom(), $urandom()};
            #1; calc_exp();
            total++; if (m_grant !== e_grant) $display("FAIL rnd_grant c=%0d act=%b exp=%b", c, m_grant, e_grant); else passed++;
            total++; if (s_sel !== e_sel) $display("FAIL rnd_sel c=%0d act=%b exp=%b", c, s_sel, e_sel); else passed++;
            total++; if (s_addr !== e_addr) $display("FAIL rnd_addr c=%0d act=%h exp=%h", c, s_addr, e_addr); else passed++;
            total++; if (s_wr !== e_wr) $display("FAIL rnd_wr c=%0d act=%b exp=%b", c, s_wr, e_wr); else passed++;
            total++; if (s_din !== e_sdin) $display("FAIL rnd_sdin c=%0d act=%h exp=%h", c, s_din, e_sdin); else passed++;
            total++; if (m_din !== e_din) $display("FAIL rnd_din c=%0d act=%h exp=%h", c, m_din, e_din); else passed++;
            total++; if (m_err !== e_err) $display("FAIL rnd_err c=%0d act=%b exp=%b", c, m_err, e_err); else passed++;
            step();
        end
        m_req = 2'b00;
        step();
    endtask

    task automatic test_async_reset();
        do_reset();
        m_req = 2'b01;
        m_addr[AW-1:0] = 16'h0010;
        s_dout = {64'h1111, 64'h2222_3333_4444_5555};
        step();
        step();
        total++; if (m_din !== 64'h2222_3333_4444_5555)
            $display("FAIL arst_pre_din act=%h exp=2222333344445555", m_din); else passed++;
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (m_grant !== 2'b00) $display("FAIL arst_grant act=%b exp=00", m_grant); else passed++;
        total++; if (s_sel !== 2'b00 || s_addr !== '0) $display("FAIL arst_sel act=%b/%h exp=00/0", s_sel, s_addr); else passed++;
        total++; if (m_din !== '0) $display("FAIL arst_din act=%h exp=0", m_din); else passed++;
        m_req = 2'b00;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_sweep4();
        int            own [6];
        logic [2:0]    sel_of [4];
        logic [DW-1:0] sv [3];
        logic [3:0]    eg;
        logic [2:0]    es;
        logic [DW-1:0] ed;
        logic          ee;
        own    = '{-1, 0, 1, 2, 3, 0};
        sel_of = '{3'b001, 3'b010, 3'b100, 3'b000};
        do_reset();
        for (int i = 0; i < 3; i++) sv[i] = {$urandom(), $urandom()};
        s_dout4 = {sv[2], sv[1], sv[0]};
        m_addr4 = {16'h4000, 16'h7800, 16'h7004, 16'h0010};
        for (int c = 0; c < 6; c++) begin
            m_req4 = 4'hF;
            if (own[c] >= 0) m_req4[own[c]] = 1'b0;
            #1;
            eg = '0; es = '0; ed = '0; ee = 1'b0;
            if (own[c] >= 0) begin
                eg[own[c]] = 1'b1;
                es = sel_of[own[c]];
            end
            if (c > 0) begin
                if (own[c-1] == 3) ee = 1'b1;
                else if (own[c-1] >= 0) ed = sv[own[c-1]];
            end
            total++; if (m_grant4 !== eg) $display("FAIL sweep_grant c=%0d act=%b exp=%b", c, m_grant4, eg); else passed++;
            total++; if (s_sel4 !== es) $display("FAIL sweep_sel c=%0d act=%b exp=%b", c, s_sel4, es); else passed++;
            total++; if (m_din4 !== ed) $display("FAIL sweep_din c=%0d act=%h exp=%h", c, m_din4, ed); else passed++;
            total++; if (m_err4 !== ee) $display("FAIL sweep_err c=%0d act=%b exp=%b", c, m_err4, ee); else passed++;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        zero_inputs();
        model_reset();
        @(negedge clk);
        test_reset();
        test_single_read();
        test_contention();
        test_lock();
        test_decode();
        test_random();
        test_async_reset();
        test_sweep4();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
